// File: rtl/pwm_light_driver.sv
// Double-buffered PWM driver: duty arrives over valid/ready into a shadow register
// and is applied at period boundaries. Define PWM_CENTER_ALIGNED_EN for up/down counting.
module pwm_light_driver #(
  parameter int unsigned PERIOD   = 10,
  parameter int unsigned PRESCALE = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [31:0] i_duty_in,
  input  logic        i_duty_valid,
  output logic        o_duty_ready,
  output logic        o_pwm_out,
  output logic        o_period_start,
  output logic [31:0] o_duty_active
);

  localparam logic [31:0] LP_PERIOD = 32'(PERIOD);
  localparam logic [31:0] LP_LAST   = 32'(PERIOD - 1);
  localparam logic [31:0] LP_PRESC  = 32'(PRESCALE);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_presc, w_presc_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_shadow, w_shadow_nxt;
  logic [31:0] r_duty, w_duty_nxt;
  logic        r_full, w_full_nxt;
  logic        r_pwm, r_period_start;
  logic        w_tick, w_bnd, w_accept, w_pwm_nxt;
`ifdef PWM_CENTER_ALIGNED_EN
  logic        r_down, w_down_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_duty_nxt   = r_duty;
    w_full_nxt   = r_full;
    w_bnd        = 1'b0;
    w_tick       = (r_presc == LP_PRESC);
    w_accept     = i_duty_valid && !r_full;
`ifdef PWM_CENTER_ALIGNED_EN
    w_down_nxt   = r_down;
`endif

    if (r_state == ST_IDLE) begin
      w_presc_nxt = '0;
      w_cnt_nxt   = '0;
`ifdef PWM_CENTER_ALIGNED_EN
      w_down_nxt  = 1'b0;
`endif
      // Leaving IDLE starts a fresh period, so it counts as a boundary.
      if (i_enable) begin
        w_state_nxt = ST_RUN;
        w_bnd       = 1'b1;
      end
    end else if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_cnt_nxt   = '0;
`ifdef PWM_CENTER_ALIGNED_EN
      w_down_nxt  = 1'b0;
`endif
    end else begin
      w_presc_nxt = w_tick ? 32'd0 : r_presc + 32'd1;
      if (w_tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
        // Endpoints are held for one extra tick at each turn-around.
        if (!r_down) begin
          if (r_cnt == LP_LAST) w_down_nxt = 1'b1;
          else                  w_cnt_nxt  = r_cnt + 32'd1;
        end else begin
          if (r_cnt == 32'd0) begin
            w_down_nxt = 1'b0;
            w_bnd      = 1'b1;
          end else begin
            w_cnt_nxt  = r_cnt - 32'd1;
          end
        end
`else
        if (r_cnt == LP_LAST) begin
          w_cnt_nxt = '0;
          w_bnd     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
`endif
      end
    end

    // Load and accept are exclusive: accept needs an empty shadow, load a full one.
    if (w_bnd && r_full) begin
      w_duty_nxt = r_shadow;
      w_full_nxt = 1'b0;
    end
    if (w_accept) begin
      w_full_nxt   = 1'b1;
      w_shadow_nxt = (i_duty_in > LP_PERIOD) ? LP_PERIOD : i_duty_in;
    end

    w_pwm_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt < w_duty_nxt);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_presc        <= '0;
      r_cnt          <= '0;
      r_shadow       <= '0;
      r_duty         <= '0;
      r_full         <= 1'b0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      r_down         <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_presc        <= w_presc_nxt;
      r_cnt          <= w_cnt_nxt;
      r_shadow       <= w_shadow_nxt;
      r_duty         <= w_duty_nxt;
      r_full         <= w_full_nxt;
      r_pwm          <= w_pwm_nxt;
      r_period_start <= w_bnd;
`ifdef PWM_CENTER_ALIGNED_EN
      r_down         <= w_down_nxt;
`endif
    end
  end

  assign o_duty_ready   = !r_full;
  assign o_pwm_out      = r_pwm;
  assign o_period_start = r_period_start;
  assign o_duty_active  = r_duty;

endmodule

// File: tb/tb_pwm_light_driver.sv
// Scoreboard bench for pwm_light_driver: a cycle-position model predicts outputs
// for the main instance; a second instance covers the prescaler.
module tb_pwm_light_driver;

  localparam int unsigned P1  = 10;
  localparam int unsigned PS1 = 0;
  localparam longint      L1  = longint'(P1) * longint'(PS1 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0, vld = 1'b0;
  logic [31:0] din = '0;
  logic        rdy, pwm, ps;
  logic [31:0] dact;

  logic        en2 = 1'b0, vld2 = 1'b0;
  logic [31:0] din2 = '0;
  logic        rdy2, pwm2, ps2;
  logic [31:0] dact2;

  pwm_light_driver #(.PERIOD(P1), .PRESCALE(PS1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_duty_in(din), .i_duty_valid(vld),
    .o_duty_ready(rdy), .o_pwm_out(pwm), .o_period_start(ps), .o_duty_active(dact)
  );

  pwm_light_driver #(.PERIOD(4), .PRESCALE(2)) u_dut_ps (
    .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_duty_in(din2), .i_duty_valid(vld2),
    .o_duty_ready(rdy2), .o_pwm_out(pwm2), .o_period_start(ps2), .o_duty_active(dact2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        pwm;
    logic        ps;
    logic        rdy;
    logic [31:0] duty;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];

  // Model tracks position within the period in clk cycles, not ticks.
  bit          m_run    = 1'b0;
  bit          m_full   = 1'b0;
  longint      m_pos    = 0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_duty   = '0;

  always @(posedge clk or posedge rst) begin : model
    bit   acc, bnd;
    exp_t e;
    if (rst) begin
      m_run = 0; m_full = 0; m_pos = 0; m_shadow = '0; m_duty = '0;
      sb.delete();
    end else begin
      acc = vld && !m_full;
      bnd = 1'b0;
      if (!en) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; bnd = 1'b1;
      end else if (m_pos == L1 - 1) begin
        m_pos = 0; bnd = 1'b1;
      end else begin
        m_pos++;
      end
      if (bnd && m_full) begin
        m_duty = m_shadow;
        m_full = 0;
      end
      if (acc) begin
        m_full   = 1;
        m_shadow = (din > P1) ? 32'(P1) : din;
      end
      e.pwm  = m_run && (m_pos < longint'(m_duty) * longint'(PS1 + 1));
      e.ps   = bnd;
      e.rdy  = !m_full;
      e.duty = m_duty;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin : scoreboard_check
    exp_t e;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      check("pwm_out", 32'(pwm), 32'(e.pwm));
      check("period_start", 32'(ps), 32'(e.ps));
      check("duty_ready", 32'(rdy), 32'(e.rdy));
      check("duty_active", dact, e.duty);
    end
  end

  // Called on a negedge; holds valid until the DUT shows ready, then one more edge.
  task automatic send(input logic [31:0] v);
    int n = 0;
    vld = 1'b1;
    din = v;
    while (rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 1'b1) check("send_timeout", 32'(rdy), 32'd1);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n;

    #1;
    check("rst_ready", 32'(rdy), 32'd1);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_duty", dact, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(2);

    // basic 3/7 PWM
    send(3);
    en = 1'b1;
    run(25);

    // double buffering: 7 lands in shadow, 5 held off until next boundary
    run(4);
    send(7);
    send(5);
    run(25);

    // extremes and clamp
    send(0);
    run(25);
    send(25);
    run(25);
    check("clamp_duty", dact, 32'd10);

    // enable drop while high
    en = 1'b0;
    @(negedge clk);
    check("drop_pwm", 32'(pwm), 32'd0);
    run(3);
    send(2);
    en = 1'b1;
    @(negedge clk);
    check("reen_pstart", 32'(ps), 32'd1);
    check("reen_duty", dact, 32'd2);
    run(6);

    // valid presented exactly at a boundary edge with empty shadow
    n = 0;
    while (!(m_run && m_pos == L1 - 1) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("bnd_align", 32'(m_pos == L1 - 1), 32'd1);
    vld = 1'b1;
    din = 32'd6;
    @(negedge clk);
    vld = 1'b0;
    check("bnd_duty_kept", dact, 32'd2);
    run(25);

    // async reset mid-period with a pending shadow value
    send(4);
    run(3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(rdy), 32'd1);
    check("mid_rst_pwm", 32'(pwm), 32'd0);
    check("mid_rst_pstart", 32'(ps), 32'd0);
    check("mid_rst_duty", dact, 32'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(5);

    // prescaler instance: PERIOD=4, PRESCALE=2, duty 1 -> 3 high / 9 low
    vld2 = 1'b1;
    din2 = 32'd1;
    @(negedge clk);
    vld2 = 1'b0;
    en2  = 1'b1;
    for (int k = 0; k < 24; k++) begin
      e.pwm  = (k % 12) < 3;
      e.ps   = (k % 12) == 0;
      e.rdy  = 1'b1;
      e.duty = 32'd1;
      sb2.push_back(e);
    end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      e = sb2.pop_front();
      check("ps_pwm", 32'(pwm2), 32'(e.pwm));
      check("ps_pstart", 32'(ps2), 32'(e.ps));
      check("ps_duty", dact2, e.duty);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
